// File: rtl/sigmoid_backprop.sv
// sigmoid_backprop: backward pass of the sigmoid activation.
// delta = g * a * (1 - a), with a = sigmoid(x) as unsigned Q8.8 and g, delta as signed Q8.8.
// A two-stage valid/ready pipeline that counts results and flags the last result of each layer.
//
// Handshake: a transfer happens on any rising edge where valid and ready are both high.
// A stage may load when it is empty, or when its content leaves on the same edge.
// in_ready is the only combinational path, and it comes from out_ready.
// Once out_valid is high, out_delta and out_last stay stable until the result is accepted.
module sigmoid_backprop #(
   parameter int LEN   = 16,
   parameter int CNT_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_act,
   input  logic [15:0] in_grad,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_delta,
   output logic        out_last
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

   logic              s1_valid_q, s1_valid_d;
   logic [6:0]        s1_dsig_q, s1_dsig_d;
   logic [15:0]       s1_grad_q, s1_grad_d;
   logic              s2_valid_q, s2_valid_d;
   logic [15:0]       delta_q, delta_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              s1_en, s2_en, out_fire;
   logic [8:0]        act_c, one_minus;
   logic [17:0]       dsig_prod;
   logic [6:0]        dsig_new;
   logic [23:0]       grad_ext, prod, prod_rnd;
   logic [15:0]       delta_new;

   // Pipeline advance enables: a stage moves when it is empty or when its content leaves.
   always_comb begin
      s2_en    = !s2_valid_q || out_ready;
      s1_en    = !s1_valid_q || s2_en;
      out_fire = s2_valid_q && out_ready;
   end

   // Stage 1 math: clamp the activation to 1.0 and form a*(1-a), rounded to Q8.8 (0x00..0x40).
   always_comb begin
      act_c     = (in_act > 16'h0100) ? 9'h100 : in_act[8:0];
      one_minus = 9'h100 - act_c;
      dsig_prod = {9'd0, act_c} * {9'd0, one_minus};
      dsig_new  = 7'((dsig_prod + 18'h80) >> 8);
   end

   // Stage 2 math: g * dsig.
   // The gradient is sign-extended to 24 bits, so the low 24 product bits are the signed result.
   // Adding 0x80 before the shift rounds half toward +inf.
   // |delta| <= |g|/4, so bits [23:8] cannot overflow.
   always_comb begin
      grad_ext  = {{8{s1_grad_q[15]}}, s1_grad_q};
      prod      = grad_ext * {17'd0, s1_dsig_q};
      prod_rnd  = prod + 24'h80;
      delta_new = 16'(prod_rnd >> 8);
   end

   // Next-state logic for both stages and the per-layer result counter.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_dsig_d  = s1_dsig_q;
      s1_grad_d  = s1_grad_q;
      s2_valid_d = s2_valid_q;
      delta_d    = delta_q;
      cnt_d      = cnt_q;
      if (s1_en) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_dsig_d = dsig_new;
            s1_grad_d = in_grad;
         end
      end
      if (s2_en) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            delta_d = delta_new;
         end
      end
      if (out_fire) begin
         cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // State registers with synchronous reset; a reset discards both stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_dsig_q  <= '0;
         s1_grad_q  <= '0;
         s2_valid_q <= 1'b0;
         delta_q    <= '0;
         cnt_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_dsig_q  <= s1_dsig_d;
         s1_grad_q  <= s1_grad_d;
         s2_valid_q <= s2_valid_d;
         delta_q    <= delta_d;
         cnt_q      <= cnt_d;
      end
   end

   assign in_ready  = s1_en;
   assign out_valid = s2_valid_q;
   assign out_delta = delta_q;
   assign out_last  = s2_valid_q && (cnt_q == LAST_CNT);

endmodule

// File: tb/tb_sigmoid_backprop.sv
// Directed bench for sigmoid_backprop.
// Two instances share the same stimulus: dut uses the default LEN=16 and dut4 uses LEN=4.
module tb_sigmoid_backprop;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_act, in_grad;
  logic        out_ready;
  logic        in_ready, out_valid, out_last;
  logic [15:0] out_delta;
  logic        in_ready4, out_valid4, out_last4;
  logic [15:0] out_delta4;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] drv_exp;
  logic [15:0] exp_q[$];
  int cnt16 = 0;
  int cnt4  = 0;
  logic stall_prev = 1'b0;
  logic [15:0] prev_delta = '0;

  typedef struct {
    logic [15:0] act;
    logic [15:0] grad;
    logic [15:0] exp_delta;
  } vec_t;
  vec_t vecs[11];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sigmoid_backprop dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_grad(in_grad), .out_valid(out_valid),
    .out_ready(out_ready), .out_delta(out_delta), .out_last(out_last)
  );

  sigmoid_backprop #(.LEN(4), .CNT_W(3)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_act(in_act), .in_grad(in_grad), .out_valid(out_valid4),
    .out_ready(out_ready), .out_delta(out_delta4), .out_last(out_last4)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Reference model written in plain integer arithmetic, with floor division for rounding.
  function automatic logic [15:0] model_delta(input logic [15:0] act, input logic [15:0] grad);
    int a, d, g, n, r;
    a = (act > 16'h0100) ? 256 : int'(act);
    d = (a * (256 - a) + 128) / 256;
    g = int'($signed(grad));
    n = g * d + 128;
    if (n >= 0) r = n / 256;
    else r = -((-n + 255) / 256);
    return r[15:0];
  endfunction

  // ---------------- driver tasks ----------------
  // Call this just after a rising edge. It returns just after the edge that accepts the input.
  task automatic send(input logic [15:0] a, input logic [15:0] g, input logic [15:0] e);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_act   = a;
    in_grad  = g;
    drv_exp  = e;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  // Inputs change 1 time unit after a rising edge, so each falling edge shows exactly the
  // handshakes that the next rising edge will perform.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      cnt16 = 0;
      cnt4  = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_delta", {16'd0, out_delta}, {16'd0, prev_delta});
      end
      if (in_valid && in_ready) exp_q.push_back(drv_exp);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          check("delta", {16'd0, out_delta}, {16'd0, exp_q.pop_front()});
        end
        check("last16", {31'd0, out_last}, {31'd0, (cnt16 == 15)});
        check("last4", {31'd0, out_last4}, {31'd0, (cnt4 == 3)});
        cnt16 = (cnt16 == 15) ? 0 : cnt16 + 1;
        cnt4  = (cnt4 == 3) ? 0 : cnt4 + 1;
      end
      stall_prev = out_valid && !out_ready;
      prev_delta = out_delta;
    end
  end

  // ---------------- test sequence ----------------
  logic [15:0] s_act[6]  = '{16'h0020, 16'h0070, 16'h00A0, 16'h00F0, 16'h0080, 16'h0110};
  logic [15:0] s_grad[6] = '{16'h0123, 16'hF00F, 16'h7FFF, 16'h8000, 16'hFF37, 16'h0200};

  initial begin
    vecs[0]  = '{16'h0080, 16'h0100, 16'h0040};
    vecs[1]  = '{16'h00C0, 16'hFF00, 16'hFFD0};
    vecs[2]  = '{16'h0000, 16'h7FFF, 16'h0000};
    vecs[3]  = '{16'h0100, 16'h7FFF, 16'h0000};
    vecs[4]  = '{16'h0180, 16'h7FFF, 16'h0000};
    vecs[5]  = '{16'h0080, 16'h8000, 16'hE000};
    vecs[6]  = '{16'h0080, 16'h0001, 16'h0000};
    vecs[7]  = '{16'h0040, 16'h0100, 16'h0030};
    vecs[8]  = '{16'h0080, 16'hFFFF, 16'h0000};
    vecs[9]  = '{16'h0080, 16'hFE80, 16'hFFA0};
    vecs[10] = '{16'h0001, 16'h7FFF, 16'h0080};

    rst = 1'b1;
    in_valid = 1'b0;
    in_act = '0;
    in_grad = '0;
    drv_exp = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_delta", {16'd0, out_delta}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // First result: out_valid rises 2 cycles after the input is accepted.
    send(16'h0080, 16'h0100, 16'h0040);
    @(negedge clk);
    check("latency_c1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("latency_c2", {31'd0, out_valid}, 32'd1);
    wait_drain();
    @(posedge clk);
    #1;

    // Table vectors: hand-computed expected values.
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].act, vecs[i].grad, vecs[i].exp_delta);
      wait_drain();
      @(posedge clk);
      #1;
    end

    // Back-pressure: out_ready is low for the edges 2..5 of a 6-input stream.
    fork
      begin
        for (int i = 0; i < 6; i++) send(s_act[i], s_grad[i], model_delta(s_act[i], s_grad[i]));
      end
      begin
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("stall_in_ready", {31'd0, in_ready}, 32'd0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Layer counting: reset, then send 9 back-to-back results.
    // The monitor checks out_last for every result against its own counter.
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      logic [15:0] a, g;
      a = 16'h0010 + 16'(i * 24);
      g = 16'h0300 - 16'(i * 200);
      send(a, g, model_delta(a, g));
    end
    wait_drain();
    check("cnt4_end", {29'd0, dut4.cnt_q}, 32'd1);
    check("cnt16_end", {24'd0, dut.cnt_q}, 32'd9);

    // Reset with both stages full.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(16'h0080, 16'h0100, 16'h0040);
    send(16'h00C0, 16'hFF00, 16'hFFD0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rstmid_cnt4", {29'd0, dut4.cnt_q}, 32'd0);
    check("rstmid_cnt16", {24'd0, dut.cnt_q}, 32'd0);
    check("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'h00C0, 16'hFF00, 16'hFFD0);
    @(negedge clk);
    check("rstmid_latency_c1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("rstmid_latency_c2", {31'd0, out_valid}, 32'd1);
    wait_drain();

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
